// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: requester count,
// index width, FSM state encoding and a one-hot to index helper.
package rr_arbiter_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index of the set bit in a one-hot vector (zero for an all-zero vector)
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Rotating first-set search: returns a one-hot vector selecting the first
// set req bit at or above ptr, wrapping from the top index back to 0.
//   req   : request vector
//   ptr   : search start index
//   pick  : one-hot selection, all-zero when req is all-zero
module rr_pick
    import rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Walk the requesters starting at ptr; index arithmetic wraps in IDX_W bits
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with bounded grant hold time.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   req       : level-sensitive request vector
//   done      : current holder finished (ignored in IDLE)
//   gnt       : registered one-hot grant (or zero)
//   gnt_valid : registered, high when gnt is non-zero
//   timeout   : registered one-cycle pulse on a forced MAX_HOLD release
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    state_t              state, state_n;
    logic [IDX_W-1:0]    ptr, ptr_n;
    logic [HOLD_W-1:0]   hold, hold_n;
    logic [NUM_REQ-1:0]  gnt_n;
    logic                gnt_valid_n;
    logic                timeout_n;

    logic [NUM_REQ-1:0]  pick;
    logic [IDX_W-1:0]    g_idx;
    logic                hold_hit;
    logic                normal_rel;

    rr_pick u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick)
    );

    assign g_idx      = onehot_to_idx(gnt);
    // hold counts 0..MAX_HOLD-1 across the grant, giving MAX_HOLD visible cycles
    assign hold_hit   = (hold == HOLD_W'(MAX_HOLD - 1));
    assign normal_rel = done || !req[g_idx];

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        hold_n      = hold;
        gnt_n       = gnt;
        gnt_valid_n = gnt_valid;
        timeout_n   = 1'b0;

        case (state)
            IDLE: begin
                gnt_n       = '0;
                gnt_valid_n = 1'b0;
                if (|req) begin
                    state_n     = GRANT;
                    gnt_n       = pick;
                    gnt_valid_n = 1'b1;
                    hold_n      = '0;
                end
            end
            GRANT: begin
                if (normal_rel || hold_hit) begin
                    state_n     = IDLE;
                    gnt_n       = '0;
                    gnt_valid_n = 1'b0;
                    // a normal release on the last cycle wins over the timeout
                    timeout_n   = hold_hit && !normal_rel;
                    ptr_n       = g_idx + IDX_W'(1);
                    hold_n      = '0;
                end else begin
                    hold_n = hold + HOLD_W'(1);
                end
            end
            default: begin
                state_n     = IDLE;
                gnt_n       = '0;
                gnt_valid_n = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold      <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold      <= hold_n;
            gnt       <= gnt_n;
            gnt_valid <= gnt_valid_n;
            timeout   <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed testbench for rr_arbiter with MAX_HOLD=4.
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int unsigned n_checks;
    int unsigned n_fails;

    rr_arbiter #(
        .NUM_REQ  (8),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then compare all outputs just after it
    task automatic cyc(input string tag, input logic [7:0] g_e, input logic to_e);
        @(posedge clk);
        #1;
        chk({tag, ".gnt"}, 32'(gnt), 32'(g_e));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(g_e != 8'h00));
        chk({tag, ".timeout"}, 32'(timeout), 32'(to_e));
    endtask

    // Continuous structural invariants
    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
            chk("valid_eq", 32'(gnt_valid), 32'(gnt != 8'h00));
        end
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        cyc("reset", 8'h00, 1'b0);
        rst = 1'b0;

        // Basic grant, done release, mandatory idle cycle, rotation
        req = 8'h05;
        cyc("basic_g0", 8'h01, 1'b0);
        done = 1'b1;
        cyc("basic_rel0", 8'h00, 1'b0);
        done = 1'b0;
        cyc("basic_g2", 8'h04, 1'b0);
        done = 1'b1;
        cyc("basic_rel2", 8'h00, 1'b0);
        req = 8'h00;
        done = 1'b0;
        cyc("idle", 8'h00, 1'b0);
        done = 1'b1;
        cyc("done_in_idle", 8'h00, 1'b0);
        done = 1'b0;

        // Full rotation with req=FF, ptr restarted at 0
        rst = 1'b1;
        cyc("reset2", 8'h00, 1'b0);
        rst = 1'b0;
        req = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            done = 1'b0;
            cyc("sweep_g", 8'(1 << k), 1'b0);
            done = 1'b1;
            cyc("sweep_rel", 8'h00, 1'b0);
        end
        done = 1'b0;
        cyc("sweep_wrap", 8'h01, 1'b0);
        done = 1'b1;
        cyc("sweep_wrap_rel", 8'h00, 1'b0);

        // Wrap from bit 7 to bit 0
        done = 1'b0;
        req  = 8'h80;
        cyc("wrap_g7", 8'h80, 1'b0);
        done = 1'b1;
        cyc("wrap_rel7", 8'h00, 1'b0);
        done = 1'b0;
        req  = 8'h81;
        cyc("wrap_g0", 8'h01, 1'b0);
        done = 1'b1;
        cyc("wrap_rel0", 8'h00, 1'b0);
        done = 1'b0;

        // Forced release after exactly 4 cycles
        req = 8'h10;
        cyc("hold_c1", 8'h10, 1'b0);
        cyc("hold_c2", 8'h10, 1'b0);
        cyc("hold_c3", 8'h10, 1'b0);
        cyc("hold_c4", 8'h10, 1'b0);
        cyc("hold_to", 8'h00, 1'b1);
        cyc("hold_regrant", 8'h10, 1'b0);

        // Request drop mid-grant
        req = 8'h00;
        cyc("drop_rel", 8'h00, 1'b0);

        // done on the last hold cycle counts as a normal release
        req = 8'h10;
        cyc("dlast_c1", 8'h10, 1'b0);
        cyc("dlast_c2", 8'h10, 1'b0);
        cyc("dlast_c3", 8'h10, 1'b0);
        cyc("dlast_c4", 8'h10, 1'b0);
        done = 1'b1;
        cyc("dlast_rel", 8'h00, 1'b0);
        done = 1'b0;

        // Request drop on the last hold cycle also counts as normal
        cyc("rlast_c1", 8'h10, 1'b0);
        cyc("rlast_c2", 8'h10, 1'b0);
        cyc("rlast_c3", 8'h10, 1'b0);
        cyc("rlast_c4", 8'h10, 1'b0);
        req = 8'h00;
        cyc("rlast_rel", 8'h00, 1'b0);

        // Reset mid-grant aborts without timeout and restores ptr=0
        req = 8'h40;
        cyc("rst_g6", 8'h40, 1'b0);
        rst = 1'b1;
        cyc("rst_abort", 8'h00, 1'b0);
        rst = 1'b0;
        req = 8'h41;
        cyc("rst_ptr0", 8'h01, 1'b0);

        // Grant holds while other requests change
        req = 8'hFF;
        cyc("hold_stable", 8'h01, 1'b0);
        done = 1'b1;
        cyc("stable_rel", 8'h00, 1'b0);
        done = 1'b0;
        req  = 8'h00;
        cyc("final_idle", 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
